fetch_stage: RTL and testbench

Instruction-fetch stage that drives the IF/D pipeline register. Owns the PC and the instruction-memory request handshake, and absorbs multi-cycle memory latency with a one-entry holding buffer. Applies decode-side stall and execute-side redirect, detects HALT and fetch errors, and presents one instruction, PC+2, error and flush per cycle to the IF/D register.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory handshake,
// buffers one response across a decode stall, and feeds the IF/D register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_done,
    input  logic        mem_err,
    output logic [15:0] instr_out,
    output logic [15:0] PC_add_2_out,
    output logic        err_out,
    output logic        flush_out
);

    localparam int unsigned W = 16;

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [W-1:0] pc;
    logic [W-1:0] pc_nxt;
    logic [W-1:0] pc_inc;
    logic         buf_valid;
    logic         buf_valid_nxt;
    logic [W-1:0] buf_instr;
    logic [W-1:0] buf_instr_nxt;
    logic         discard;
    logic         discard_nxt;
    logic         deliver;
    logic [W-1:0] deliver_instr;
    logic [1:0]   redirect_state;

    // HALT opcode occupies the top five bits.
    function automatic logic is_halt(input logic [W-1:0] instr);
        return (instr[15:11] == 5'b00000);
    endfunction

    assign pc_inc         = pc + W'(2);
    assign mem_addr       = pc;
    assign PC_add_2_out   = pc_inc;
    // A misaligned redirect target is a fetch error rather than a new fetch.
    assign redirect_state = redirect_pc[0] ? ERROR : FETCH;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            buf_instr <= NOP_INSTR;
            discard   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_valid <= buf_valid_nxt;
            buf_instr <= buf_instr_nxt;
            discard   <= discard_nxt;
        end
    end

    // Next-state and combinational outputs.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        buf_valid_nxt = buf_valid;
        buf_instr_nxt = buf_instr;
        discard_nxt   = discard;
        mem_rd        = 1'b0;
        instr_out     = NOP_INSTR;
        err_out       = 1'b0;
        flush_out     = redirect;
        deliver       = 1'b0;
        deliver_instr = mem_data;

        case (state)
            FETCH: begin
                mem_rd = !stall_in && !redirect && !buf_valid;
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    buf_valid_nxt = 1'b0;
                    state_nxt     = redirect_state;
                end else if (buf_valid) begin
                    if (!stall_in) begin
                        deliver       = 1'b1;
                        deliver_instr = buf_instr;
                    end
                end else if (!stall_in) begin
                    if (mem_done) begin
                        if (mem_err) begin
                            err_out   = 1'b1;
                            state_nxt = ERROR;
                        end else begin
                            deliver = 1'b1;
                        end
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end

            WAIT: begin
                mem_rd = 1'b1;
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    buf_valid_nxt = 1'b0;
                    if (redirect_pc[0]) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ERROR;
                    end else if (mem_done) begin
                        // Wrong-path response lands with the redirect: drop it now.
                        discard_nxt = 1'b0;
                        state_nxt   = FETCH;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (mem_done) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = FETCH;
                    end else if (mem_err) begin
                        err_out   = 1'b1;
                        state_nxt = ERROR;
                    end else if (stall_in) begin
                        buf_instr_nxt = mem_data;
                        buf_valid_nxt = 1'b1;
                        state_nxt     = FETCH;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end

            HALTED: begin
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    buf_valid_nxt = 1'b0;
                    state_nxt     = redirect_state;
                end
            end

            ERROR: begin
                err_out = 1'b1;
            end
        endcase

        if (deliver) begin
            instr_out     = deliver_instr;
            pc_nxt        = pc_inc;
            buf_valid_nxt = 1'b0;
            state_nxt     = is_halt(deliver_instr) ? HALTED : FETCH;
        end

        // Outputs stay quiet while reset is held.
        if (!rst) begin
            mem_rd    = 1'b0;
            instr_out = NOP_INSTR;
            err_out   = 1'b0;
            flush_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: deliveries are predicted as stimulus is driven
// and matched by a monitor; each scenario task checks handshake outputs inline.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_done;
    logic        mem_err;
    logic [15:0] instr_out;
    logic [15:0] PC_add_2_out;
    logic        err_out;
    logic        flush_out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_bad;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_done    (mem_done),
        .mem_err     (mem_err),
        .instr_out   (instr_out),
        .PC_add_2_out(PC_add_2_out),
        .err_out     (err_out),
        .flush_out   (flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    // Any non-NOP instruction is a delivery and must match the next prediction.
    always @(negedge clk) begin
        #1;
        if (rst === 1'b1 && instr_out !== NOP) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got instr %h pc2 %h, want no delivery", instr_out, PC_add_2_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr_out !== mon_e.instr || PC_add_2_out !== mon_e.pc2) begin
                    n_bad++;
                    $display("FAIL sb_deliver: got instr %h pc2 %h, want instr %h pc2 %h",
                             instr_out, PC_add_2_out, mon_e.instr, mon_e.pc2);
                end
            end
        end
    end

    task automatic set_in(input logic st, input logic rd, input logic [15:0] rpc,
                          input logic dn, input logic er, input logic [15:0] d);
        stall_in    = st;
        redirect    = rd;
        redirect_pc = rpc;
        mem_done    = dn;
        mem_err     = er;
        mem_data    = d;
    endtask

    task automatic idle();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic push_exp(input logic [15:0] i, input logic [15:0] p2);
        exp_t e;
        e.instr = i;
        e.pc2   = p2;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        n_cmp++;
        if (mem_rd !== 1'b0 || instr_out !== NOP || err_out !== 1'b0 || flush_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rd %b instr %h err %b flush %b, want 0 0800 0 0",
                     mem_rd, instr_out, err_out, flush_out);
        end
        n_cmp++;
        if (PC_add_2_out !== 16'h0002 || mem_addr !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_pc: got addr %h pc2 %h, want 0000 0002", mem_addr, PC_add_2_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_hits();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4001 + 16'(i));
            push_exp(16'h4001 + 16'(i), 16'(2 * i + 2));
            #1;
            n_cmp++;
            if (mem_rd !== 1'b1 || mem_addr !== 16'(2 * i)) begin
                n_bad++;
                $display("FAIL hits_req%0d: got rd %b addr %h, want 1 %h", i, mem_rd, mem_addr, 16'(2 * i));
            end
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL hits_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_miss();
        @(negedge clk);
        set_in(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (flush_out !== 1'b1 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_redirect: got flush %b rd %b, want 1 0", flush_out, mem_rd);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            #1;
            n_cmp++;
            if (mem_rd !== 1'b1 || mem_addr !== 16'h0010 || instr_out !== NOP) begin
                n_bad++;
                $display("FAIL miss_wait%0d: got rd %b addr %h instr %h, want 1 0010 0800",
                         i, mem_rd, mem_addr, instr_out);
            end
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hA5A5);
        push_exp(16'hA5A5, 16'h0012);
        #1;
        n_cmp++;
        if (mem_addr !== 16'h0010) begin
            n_bad++;
            $display("FAIL miss_done_addr: got %h, want 0010", mem_addr);
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL miss_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stall_buffer();
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0012) begin
            n_bad++;
            $display("FAIL buf_req: got rd %b addr %h, want 1 0012", mem_rd, mem_addr);
        end
        @(negedge clk);
        set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234);
        #1;
        n_cmp++;
        if (instr_out !== NOP || mem_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL buf_latch: got instr %h rd %b, want 0800 1", instr_out, mem_rd);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle();
            #1;
            n_cmp++;
            if (mem_rd !== 1'b0 || instr_out !== NOP) begin
                n_bad++;
                $display("FAIL buf_hold%0d: got rd %b instr %h, want 0 0800", i, mem_rd, instr_out);
            end
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        push_exp(16'h1234, 16'h0014);
        #1;
        n_cmp++;
        if (mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL buf_release_rd: got %b, want 0", mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4444);
        push_exp(16'h4444, 16'h0016);
        #1;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0014) begin
            n_bad++;
            $display("FAIL buf_next_req: got rd %b addr %h, want 1 0014", mem_rd, mem_addr);
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL buf_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_redirect_mid_miss();
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        set_in(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (flush_out !== 1'b1 || instr_out !== NOP) begin
            n_bad++;
            $display("FAIL redir_flush: got flush %b instr %h, want 1 0800", flush_out, instr_out);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5555);
        #1;
        n_cmp++;
        if (instr_out !== NOP || mem_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL redir_drop: got instr %h rd %b, want 0800 1", instr_out, mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h6001);
        push_exp(16'h6001, 16'h0102);
        #1;
        n_cmp++;
        if (mem_addr !== 16'h0100 || mem_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL redir_target: got addr %h rd %b, want 0100 1", mem_addr, mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        set_in(1'b0, 1'b1, 16'h0180, 1'b1, 1'b0, 16'h7777);
        #1;
        n_cmp++;
        if (flush_out !== 1'b1 || instr_out !== NOP) begin
            n_bad++;
            $display("FAIL redir_same_cycle: got flush %b instr %h, want 1 0800", flush_out, instr_out);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h6002);
        push_exp(16'h6002, 16'h0182);
        #1;
        n_cmp++;
        if (mem_addr !== 16'h0180 || mem_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL redir_same_target: got addr %h rd %b, want 0180 1", mem_addr, mem_rd);
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL redir_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stall_redirect_wrap();
        @(negedge clk);
        set_in(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (flush_out !== 1'b1 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_redirect: got flush %b rd %b, want 1 0", flush_out, mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4100);
        push_exp(16'h4100, 16'h0000);
        #1;
        n_cmp++;
        if (mem_addr !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL wrap_addr_hi: got %h, want fffe", mem_addr);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4101);
        push_exp(16'h4101, 16'h0002);
        #1;
        n_cmp++;
        if (mem_addr !== 16'h0000 || err_out !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_addr_lo: got addr %h err %b, want 0000 0", mem_addr, err_out);
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_halt();
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        push_exp(16'h0000, 16'h0004);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            #1;
            n_cmp++;
            if (mem_rd !== 1'b0 || instr_out !== NOP || mem_addr !== 16'h0004) begin
                n_bad++;
                $display("FAIL halt_idle%0d: got rd %b instr %h addr %h, want 0 0800 0004",
                         i, mem_rd, instr_out, mem_addr);
            end
        end
        @(negedge clk);
        set_in(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (flush_out !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_flush: got %b, want 1", flush_out);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4200);
        push_exp(16'h4200, 16'h0202);
        #1;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin
            n_bad++;
            $display("FAIL halt_resume: got rd %b addr %h, want 1 0200", mem_rd, mem_addr);
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL halt_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4300);
        #1;
        n_cmp++;
        if (err_out !== 1'b1 || instr_out !== NOP) begin
            n_bad++;
            $display("FAIL err_detect: got err %b instr %h, want 1 0800", err_out, instr_out);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (err_out !== 1'b1 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL err_sticky: got err %b rd %b, want 1 0", err_out, mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (err_out !== 1'b1 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL err_redirect: got err %b rd %b, want 1 0", err_out, mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (err_out !== 1'b1 || mem_addr !== 16'h0202 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL err_frozen: got err %b addr %h rd %b, want 1 0202 0", err_out, mem_addr, mem_rd);
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (err_out !== 1'b0 || mem_addr !== 16'h0000) begin
            n_bad++;
            $display("FAIL err_async_clear: got err %b addr %h, want 0 0000", err_out, mem_addr);
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
    endtask

    task automatic test_odd_redirect();
        @(negedge clk);
        set_in(1'b0, 1'b1, 16'h0031, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        n_cmp++;
        if (err_out !== 1'b1 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL odd_redirect: got err %b rd %b, want 1 0", err_out, mem_rd);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle();
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL rstwait_rd: got %b, want 0", mem_rd);
        end
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4999);
        #1;
        n_cmp++;
        if (instr_out !== NOP || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL rstwait_stale: got instr %h rd %b, want 0800 0", instr_out, mem_rd);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4ABC);
        push_exp(16'h4ABC, 16'h0002);
        #1;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
            n_bad++;
            $display("FAIL rstwait_refetch: got rd %b addr %h, want 1 0000", mem_rd, mem_addr);
        end
        @(negedge clk);
        idle();
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rstwait_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_hits();
        test_miss();
        test_stall_buffer();
        test_redirect_mid_miss();
        test_stall_redirect_wrap();
        test_halt();
        test_error();
        test_odd_redirect();
        test_reset_mid_wait();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
